// File: rtl/agc_wrout_handoff_ctrl.sv
// rtl/agc_wrout_handoff_ctrl.sv - AGC sample FIFO with toggle-ack hand-off to software PIOs
module agc_wrout_handoff_ctrl #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     s_valid,
   input  logic [DATA_W-1:0]        s_data,
   input  logic [1:0]               ctrl_in,
   output logic [1:0]               status,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

   state_t              state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [1:0]          ctrl_m;
   logic [1:0]          ctrl_s;
   logic                ack_prev;
   logic                avail;
   logic                overflow;

   logic ack_edge;
   logic clr_s;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign ack_edge = ctrl_s[0] ^ ack_prev;
   assign clr_s    = ctrl_s[1];
   assign full     = (count == CW'(DEPTH));
   assign pop      = (state == LOAD);
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign push     = s_valid && (!full || pop);
   assign drop     = s_valid && full && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_m   <= 2'b00;
         ctrl_s   <= 2'b00;
         ack_prev <= 1'b0;
      end else begin
         ctrl_m   <= ctrl_in;
         ctrl_s   <= ctrl_m;
         ack_prev <= ctrl_s[0];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (clr_s)
         overflow <= 1'b0;
   end

   // Ack edges outside PRESENT are discarded, including the one seen after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         avail    <= 1'b0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               avail <= 1'b0;
               if (count != '0)
                  state <= LOAD;
            end
            LOAD: begin
               out_data <= mem[rd_ptr];
               avail    <= 1'b1;
               state    <= PRESENT;
            end
            PRESENT: begin
               if (ack_edge) begin
                  avail <= 1'b0;
                  state <= (count != '0) ? LOAD : IDLE;
               end
            end
            default: begin
               avail <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign status     = {overflow, avail};
   assign fill_level = count;

endmodule

// File: tb/tb_agc_wrout_handoff_ctrl.sv
// tb/tb_agc_wrout_handoff_ctrl.sv - directed self-checking bench for agc_wrout_handoff_ctrl
module tb_agc_wrout_handoff_ctrl;

   logic        clk;
   logic        reset_n;
   logic        s_valid;
   logic [15:0] s_data;
   logic [1:0]  ctrl_in;
   logic [1:0]  status;
   logic [15:0] out_data;
   logic [3:0]  fill_level;

   int tests;
   int fails;

   agc_wrout_handoff_ctrl #(.DATA_W(16), .DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .ctrl_in    (ctrl_in),
      .status     (status),
      .out_data   (out_data),
      .fill_level (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      ctrl_in = 2'b01;
      s_valid = 1'b0;
      s_data  = 16'h0;
      repeat (3) tick();
      tests++; if (status !== 2'b00) begin fails++; $display("FAIL reset_status got=%b exp=00", status); end
      tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
      tests++; if (fill_level !== 4'd0) begin fails++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (status !== 2'b00 || fill_level !== 4'd0) begin
            fails++;
            $display("FAIL reset_idle cyc=%0d status=%b fill=%0d exp status=00 fill=0", i, status, fill_level);
         end
      end
   endtask

   task automatic test_single;
      tick();
      s_valid = 1'b1; s_data = 16'h1234;
      tick();
      s_valid = 1'b0;
      tick();
      tests++; if (status !== 2'b00) begin fails++; $display("FAIL single_early got=%b exp=00", status); end
      tick();
      tests++; if (status !== 2'b01) begin fails++; $display("FAIL single_status got=%b exp=01", status); end
      tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL single_data got=%h exp=1234", out_data); end
      ctrl_in[0] = ~ctrl_in[0];
      tick();
      tick();
      tests++; if (status[0] !== 1'b1) begin fails++; $display("FAIL single_ack_early got=%b exp=1", status[0]); end
      tick();
      tests++; if (status !== 2'b00) begin fails++; $display("FAIL single_ack_drop got=%b exp=00", status); end
      tests++; if (fill_level !== 4'd0) begin fails++; $display("FAIL single_fill got=%0d exp=0", fill_level); end
      tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL single_retain got=%h exp=1234", out_data); end
   endtask

   task automatic test_backlog;
      int peak;
      peak = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 16'(i + 1);
         if (int'(fill_level) > peak) peak = int'(fill_level);
         if (i == 3) begin
            tests++;
            if (status !== 2'b01 || out_data !== 16'h0001) begin
               fails++;
               $display("FAIL backlog_first status=%b data=%h exp status=01 data=0001", status, out_data);
            end
         end
         tick();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (int'(fill_level) > peak) peak = int'(fill_level);
         tick();
      end
      tests++; if (peak != 3) begin fails++; $display("FAIL backlog_peak got=%0d exp=3", peak); end
      for (int k = 2; k <= 4; k++) begin
         ctrl_in[0] = ~ctrl_in[0];
         repeat (3) tick();
         tests++; if (status[0] !== 1'b0) begin fails++; $display("FAIL backlog_gap k=%0d got=%b exp=0", k, status[0]); end
         tick();
         tests++;
         if (status[0] !== 1'b1 || out_data !== 16'(k)) begin
            fails++;
            $display("FAIL backlog_next k=%0d avail=%b data=%h exp avail=1 data=%h", k, status[0], out_data, 16'(k));
         end
      end
      ctrl_in[0] = ~ctrl_in[0];
      repeat (3) tick();
      tests++; if (status[0] !== 1'b0) begin fails++; $display("FAIL backlog_last_drop got=%b exp=0", status[0]); end
      tick();
      tests++;
      if (status[0] !== 1'b0 || fill_level !== 4'd0) begin
         fails++;
         $display("FAIL backlog_idle avail=%b fill=%0d exp avail=0 fill=0", status[0], fill_level);
      end
   endtask

   task automatic test_overflow;
      tick();
      for (int i = 1; i <= 10; i++) begin
         s_valid = 1'b1; s_data = 16'(i);
         tick();
      end
      s_valid = 1'b0;
      repeat (2) tick();
      tests++; if (status !== 2'b11) begin fails++; $display("FAIL ovf_status got=%b exp=11", status); end
      tests++; if (fill_level !== 4'd8) begin fails++; $display("FAIL ovf_fill got=%0d exp=8", fill_level); end
      tests++; if (out_data !== 16'h0001) begin fails++; $display("FAIL ovf_head got=%h exp=0001", out_data); end
   endtask

   task automatic test_overflow_race;
      ctrl_in[1] = 1'b1;
      tick();
      ctrl_in[1] = 1'b0;
      tick();
      s_valid = 1'b1; s_data = 16'hdead;
      tick();
      s_valid = 1'b0;
      tests++; if (status[1] !== 1'b1) begin fails++; $display("FAIL race_set_wins got=%b exp=1", status[1]); end
      tests++; if (fill_level !== 4'd8) begin fails++; $display("FAIL race_fill got=%0d exp=8", fill_level); end
      ctrl_in[1] = 1'b1;
      tick();
      ctrl_in[1] = 1'b0;
      tick();
      tests++; if (status[1] !== 1'b1) begin fails++; $display("FAIL clr_early got=%b exp=1", status[1]); end
      tick();
      tests++; if (status[1] !== 1'b0) begin fails++; $display("FAIL clr_only got=%b exp=0", status[1]); end
      for (int k = 2; k <= 9; k++) begin
         ctrl_in[0] = ~ctrl_in[0];
         repeat (4) tick();
         tests++;
         if (status[0] !== 1'b1 || out_data !== 16'(k)) begin
            fails++;
            $display("FAIL ovf_order k=%0d avail=%b data=%h exp avail=1 data=%h", k, status[0], out_data, 16'(k));
         end
      end
      ctrl_in[0] = ~ctrl_in[0];
      repeat (5) tick();
      tests++;
      if (status !== 2'b00 || fill_level !== 4'd0) begin
         fails++;
         $display("FAIL ovf_drained status=%b fill=%0d exp status=00 fill=0", status, fill_level);
      end
   endtask

   task automatic test_reset_mid;
      tick();
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 16'h00a0 + 16'(i);
         tick();
      end
      s_valid = 1'b0;
      repeat (2) tick();
      tests++;
      if (status !== 2'b01 || fill_level !== 4'd3 || out_data !== 16'h00a0) begin
         fails++;
         $display("FAIL mid_setup status=%b fill=%0d data=%h exp status=01 fill=3 data=00a0", status, fill_level, out_data);
      end
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      tests++;
      if (status !== 2'b00 || out_data !== 16'h0 || fill_level !== 4'd0) begin
         fails++;
         $display("FAIL mid_async status=%b data=%h fill=%0d exp all zero", status, out_data, fill_level);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++;
         if (status !== 2'b00 || fill_level !== 4'd0) begin
            fails++;
            $display("FAIL mid_quiet cyc=%0d status=%b fill=%0d exp status=00 fill=0", i, status, fill_level);
         end
      end
      s_valid = 1'b1; s_data = 16'hbeef;
      tick();
      s_valid = 1'b0;
      repeat (2) tick();
      tests++;
      if (status !== 2'b01 || out_data !== 16'hbeef) begin
         fails++;
         $display("FAIL mid_new status=%b data=%h exp status=01 data=beef", status, out_data);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_backlog();
      test_overflow();
      test_overflow_race();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/agc_wrout_handoff_ctrl.md
Name: agc_wrout_handoff_ctrl

Overview:
Sequences the hand-off of AGC output samples to Nios II software through the PIO pair.
- Buffers samples from the AGC datapath in a small FIFO.
- Presents one sample at a time on a data word for a PIO input port.
- Drives a 2-bit status word intended for the 2-bit wr-out PIO input port.
- Software consumes a sample by toggling an acknowledge bit on an output PIO. No Avalon logic lives here; the PIOs provide the bus side.

Parameters:
DATA_W, 16, sample width in bits.
DEPTH, 8, FIFO depth in samples; power of 2, minimum 2.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
s_valid  in  1  one-cycle strobe; AGC sample present on s_data. The source cannot stall.
s_data  in  DATA_W  AGC sample.
ctrl_in  in  2  from software output PIO, asynchronous to sample events. Bit0 = ack toggle; bit1 = overflow clear (level).
status  out  2  to wr-out PIO in_port. Bit0 = sample_avail; bit1 = overflow (sticky).
out_data  out  DATA_W  currently presented sample, to data PIO in_port.
fill_level  out  clog2(DEPTH)+1  FIFO occupancy, excluding the presented sample.

Behaviour:
- Reset (asynchronous, active-low):
  - status=0, out_data=0, fill_level=0.
  - FIFO pointers=0, FSM=IDLE, all sync/edge flops=0.
- Synchronisation:
  - ctrl_in passes through 2-flop synchronisers, giving ack_s and clr_s.
  - ack_edge = ack_s XOR ack_prev, with ack_prev registered from ack_s.
  - A ctrl_in[0] change in cycle M yields ack_edge in cycle M+2.
- FIFO write:
  - s_valid with FIFO not full: write at the clock edge; count increments.
  - s_valid with FIFO full and no pop in the same cycle: sample dropped, count unchanged, overflow set.
  - s_valid with FIFO full and a pop in the same cycle: sample accepted, count unchanged, no overflow.
  - Push and pop in the same cycle with FIFO not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: status[0]=0. If count>0, go to LOAD.
  - LOAD: pop FIFO head; out_data <= head (registered); go to PRESENT.
  - PRESENT: status[0]=1; out_data held stable. On ack_edge: if count>0 go to LOAD, else go to IDLE.
- Edge handling:
  - ack_edge in IDLE or LOAD is ignored. This covers the spurious edge after reset when ctrl_in[0]=1.
  - Each accepted ack consumes exactly one sample.
- Latency:
  - s_valid in cycle N with FSM in IDLE and FIFO empty: FSM in LOAD during N+2; status[0]=1 and out_data valid in N+3.
  - Ack toggle at cycle M while in PRESENT: status[0]=0 from M+3, in both the LOAD and IDLE paths.
  - With a backlog, next status[0]=1 at M+4, giving a one-cycle gap so software sees the flag drop.
- out_data retains its last value in IDLE; it is not cleared.
- Overflow (status[1]):
  - Set on a dropped sample.
  - Cleared on any cycle with clr_s=1.
  - Set wins over clear when both happen in the same cycle.
- fill_level = registered count; range 0..DEPTH.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: reset_n low 3 cycles, ctrl_in=2'b01 → status=0, out_data=0, fill_level=0; after release, no state change and status[0] stays 0 despite the synchronised ack edge.
- Single sample: s_valid with s_data=16'h1234 at cycle N → status=2'b01 and out_data=16'h1234 at N+3. Toggle ctrl_in[0] at M → status[0]=0 from M+3, fill_level=0.
- Backlog ordering: 4 back-to-back samples 0x0001..0x0004 → presented in order. fill_level peaks at 3. Each ack gives a status[0] low gap of 1 cycle, then the next value 4 cycles after the toggle.
- Overflow (DEPTH=8): 10 samples, no acks → first sample presented, FIFO holds 8, 10th sample dropped, status=2'b11, fill_level=8. Acks return samples 1..9 in order.
- Overflow clear vs set race: clr_s high in the same cycle as a drop → status[1] stays 1. clr_s high with no drop → status[1]=0 the next cycle.
- Reset mid-PRESENT with 3 queued: reset_n asserted asynchronously → status, out_data and fill_level go to 0 immediately without waiting for clk. After release, no sample is presented until a new s_valid.
